inst_issue_queue: RTL and testbench
===================================

Name: inst_issue_queue

Overview:
- Upstream feeder for CONTROL_UNIT. Buffers instruction words pushed by the host/AXI side in a FIFO.
- Presents one instruction at a time on `instruction` and holds it for the opcode-specific cycle budget the CU requires.
- When the queue runs dry it drives IDLE_INST.
- Replaces the hand-timed instruction sequencing currently done in simulation with a hardware issue engine.

Parameters:
- OPCODE_BITS, 4, opcode field width (instruction MSBs).
- ADDR_BITS, 8, width of each of ADDRA and ADDRB.
- OPERAND_BITS, 128, operand field width (16 x int8, LSBs).
- INST_BITS, OPCODE_BITS+2*ADDR_BITS+OPERAND_BITS, full instruction width. Layout from MSB: {opcode, addra, addrb, operand}.
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- IDLE_CYCLE, 1, hold cycles for opcode 0 (IDLE) and for any undefined opcode (7..15).
- AXI_TO_UB_CYCLE, 1, hold cycles for opcode 1.
- AXI_TO_WB_CYCLE, 1, hold cycles for opcode 2.
- UB_TO_DATA_FIFO_CYCLE, 1, hold cycles for opcode 3.
- UB_TO_WEIGHT_FIFO_CYCLE, 1, hold cycles for opcode 4.
- MAT_MUL_CYCLE, 48, hold cycles for opcode 5 (MAT_MUL) and opcode 6 (MAT_MUL_ACC).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset, in, 1, synchronous active-high reset.
- s_inst_valid, in, 1, host has an instruction on s_inst_data.
- s_inst_ready, out, 1, queue can accept; equals !full.
- s_inst_data, in, INST_BITS, instruction word to enqueue.
- stall, in, 1, CU back-pressure; freezes issue.
- instruction, out, INST_BITS, instruction currently driven to CONTROL_UNIT.
- inst_start, out, 1, one-cycle pulse in the first cycle a dequeued instruction is presented.
- busy, out, 1, high while a dequeued instruction is being held.
- fifo_count, out, $clog2(DEPTH)+1, number of stored, not-yet-issued entries.
- issued_count, out, 16, count of instructions dequeued; wraps 0xFFFF to 0.

Behaviour:
- **Reset** (reset=1 at an edge, any state, including mid-hold):
  - FIFO pointers cleared; all contents discarded.
  - State EMPTY, counter 0.
  - instruction = all-zero (IDLE_INST).
  - inst_start=0, busy=0, fifo_count=0, issued_count=0.
  - s_inst_ready=1 in the cycle after reset deasserts.
- **Enqueue:** occurs on an edge where s_inst_valid && s_inst_ready. s_inst_ready is combinational !full. When full, no push occurs even if a pop happens that same edge; the host retries the next cycle.
- **Hold length:** N = cycle parameter selected by the opcode of the dequeued word. A parameter value of 0 is treated as 1.
- **FSM state EMPTY:**
  - instruction = 0, busy=0.
  - If the FIFO is non-empty and stall=0 at an edge: pop head into the instruction register, load counter=N, go to EXEC, issued_count+1.
  - Minimum latency: a word accepted at edge k into an empty, idle queue is on `instruction` after edge k+1, with inst_start=1 for that cycle.
- **FSM state EXEC:**
  - busy=1; instruction held stable.
  - On each edge with stall=0, the counter decrements.
  - At an edge where counter==1 and stall=0:
    - If the FIFO is non-empty: pop the next word back-to-back (no bubble), reload counter, stay in EXEC, inst_start=1 the next cycle.
    - Otherwise: go to EMPTY and drive instruction=0 the next cycle.
  - So each instruction is presented for exactly N unstalled cycles.
- **stall:**
  - In EXEC: counter frozen, no pop, instruction held.
  - In EMPTY: no pop.
  - stall never blocks enqueue.
- **Simultaneous push and pop:** fifo_count unchanged. The pushed word does not bypass; it issues only after all older entries.
- **Pointer wrap:** pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

Test Plan:
- **Reset / idle:** assert reset 2 cycles then release, no pushes → instruction=0, busy=0, fifo_count=0, s_inst_ready=1.
- **Single issue:** push opcode 5, ADDRA=3, ADDRB=7 (MAT_MUL_CYCLE=48) into an empty queue at edge k → instruction equals the pushed word from edge k+1 through edge k+49; inst_start high only in the first cycle; instruction=0 afterwards.
- **Back-to-back:** push 5 × UB_TO_DATA_FIFO (ADDRB=0..4) then 21 × UB_TO_WEIGHT_FIFO (ADDRB=0..20) → 26 consecutive one-cycle issues in order with no zero gaps; issued_count=26.
- **Full:** with stall=1 push 17 words → first 16 accepted, s_inst_ready=0, fifo_count=16. Release stall → after the first pop s_inst_ready=1 and the 17th word is accepted and issues last.
- **Stall mid-hold:** stall=1 for 10 cycles starting at cycle 20 of a MAT_MUL → instruction held for 58 cycles total; the next entry follows with no bubble.
- **Reset mid-operation:** reset during a MAT_MUL with 5 entries queued → next cycle instruction=0, fifo_count=0, issued_count=0; nothing issues afterwards without new pushes.

Source files
------------

// File: rtl/inst_issue_queue.sv
// Instruction issue queue feeding CONTROL_UNIT: a FIFO of instruction words,
// issued one at a time and held for an opcode-dependent number of cycles.
module inst_issue_queue #(
    parameter int OPCODE_BITS             = 4,
    parameter int ADDR_BITS               = 8,
    parameter int OPERAND_BITS            = 128,
    parameter int INST_BITS               = OPCODE_BITS + 2*ADDR_BITS + OPERAND_BITS,
    parameter int DEPTH                   = 16,
    parameter int IDLE_CYCLE              = 1,
    parameter int AXI_TO_UB_CYCLE         = 1,
    parameter int AXI_TO_WB_CYCLE         = 1,
    parameter int UB_TO_DATA_FIFO_CYCLE   = 1,
    parameter int UB_TO_WEIGHT_FIFO_CYCLE = 1,
    parameter int MAT_MUL_CYCLE           = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_inst_valid,
    output logic                     s_inst_ready,
    input  logic [INST_BITS-1:0]     s_inst_data,
    input  logic                     stall,
    output logic [INST_BITS-1:0]     instruction,
    output logic                     inst_start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_EXEC  = 1'b1;

    localparam logic [OPCODE_BITS-1:0] OP_AXI_TO_UB  = 1;
    localparam logic [OPCODE_BITS-1:0] OP_AXI_TO_WB  = 2;
    localparam logic [OPCODE_BITS-1:0] OP_UB_TO_DF   = 3;
    localparam logic [OPCODE_BITS-1:0] OP_UB_TO_WF   = 4;
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL    = 5;
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL_AC = 6;

    logic [INST_BITS-1:0]   mem [DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [0:0]             state;
    logic [15:0]            counter;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [INST_BITS-1:0]   head;
    logic [OPCODE_BITS-1:0] head_op;

    // Zero-valued cycle parameters still hold for one cycle.
    function automatic logic [15:0] hold_len(input logic [OPCODE_BITS-1:0] op);
        int n;
        case (op)
            OP_AXI_TO_UB:  n = AXI_TO_UB_CYCLE;
            OP_AXI_TO_WB:  n = AXI_TO_WB_CYCLE;
            OP_UB_TO_DF:   n = UB_TO_DATA_FIFO_CYCLE;
            OP_UB_TO_WF:   n = UB_TO_WEIGHT_FIFO_CYCLE;
            OP_MAT_MUL:    n = MAT_MUL_CYCLE;
            OP_MAT_MUL_AC: n = MAT_MUL_CYCLE;
            default:       n = IDLE_CYCLE;
        endcase
        if (n < 1) n = 1;
        return 16'(n);
    endfunction

    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        s_inst_ready = !full;
        push         = s_inst_valid && !full;
        pop          = !stall && !empty && ((state == S_EMPTY) || (counter == 16'd1));
        head         = mem[rd_ptr[AW-1:0]];
        head_op      = head[INST_BITS-1 -: OPCODE_BITS];
        busy         = (state == S_EXEC);
        fifo_count   = wr_ptr - rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_inst_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            state        <= S_EMPTY;
            counter      <= '0;
            instruction  <= '0;
            inst_start   <= 1'b0;
            issued_count <= '0;
        end else begin
            inst_start <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                instruction  <= head;
                counter      <= hold_len(head_op);
                state        <= S_EXEC;
                issued_count <= issued_count + 16'd1;
            end else if (state == S_EXEC && !stall) begin
                if (counter == 16'd1) begin
                    state       <= S_EMPTY;
                    counter     <= '0;
                    instruction <= '0;
                end else begin
                    counter <= counter - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: idle, single issue, back-to-back,
// full queue, stall mid-hold and reset mid-operation.
module tb_inst_issue_queue;

    localparam int IW = 148;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_inst_valid;
    logic          s_inst_ready;
    logic [IW-1:0] s_inst_data;
    logic          stall;
    logic [IW-1:0] instruction;
    logic          inst_start;
    logic          busy;
    logic [4:0]    fifo_count;
    logic [15:0]   issued_count;

    int tests_run = 0;
    int tests_failed = 0;

    inst_issue_queue dut (
        .clk(clk), .reset(reset),
        .s_inst_valid(s_inst_valid), .s_inst_ready(s_inst_ready), .s_inst_data(s_inst_data),
        .stall(stall), .instruction(instruction), .inst_start(inst_start), .busy(busy),
        .fifo_count(fifo_count), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [127:0] d);
        return {op, a, b, d};
    endfunction

    task automatic do_reset();
        reset = 1'b1; s_inst_valid = 1'b0; s_inst_data = '0; stall = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    logic [IW-1:0] words [32];

    initial begin
        logic [IW-1:0] w;
        logic [IW-1:0] w2;
        int held;
        int starts;
        int guard;

        // Reset / idle
        do_reset();
        tick();
        chk("idle_inst", instruction, 0);
        chk("idle_busy", busy, 0);
        chk("idle_count", fifo_count, 0);
        chk("idle_ready", s_inst_ready, 1);
        chk("idle_issued", issued_count, 0);
        chk("idle_start", inst_start, 0);

        // Single MAT_MUL issue
        w = mk(4'd5, 8'd3, 8'd7, 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10);
        s_inst_valid = 1'b1; s_inst_data = w;
        tick();
        s_inst_valid = 1'b0;
        chk("single_pre_inst", instruction, 0);
        chk("single_pre_count", fifo_count, 1);
        tick();
        chk("single_first", instruction, w);
        chk("single_start", inst_start, 1);
        chk("single_busy", busy, 1);
        held = 0; starts = 0; guard = 0;
        while (instruction == w && guard < 200) begin
            held++;
            if (inst_start) starts++;
            tick();
            guard++;
        end
        chk("single_hold_len", held, 48);
        chk("single_start_pulses", starts, 1);
        chk("single_after", instruction, 0);
        chk("single_after_busy", busy, 0);
        chk("single_issued", issued_count, 1);

        // Back-to-back one-cycle issues
        do_reset();
        for (int i = 0; i < 26; i++)
            words[i] = (i < 5) ? mk(4'd3, 8'd0, 8'(i), 128'(i * 7 + 1))
                               : mk(4'd4, 8'd0, 8'(i - 5), 128'(i * 7 + 1));
        fork
            begin
                for (int i = 0; i < 26; i++) begin
                    s_inst_valid = 1'b1; s_inst_data = words[i];
                    tick();
                end
                s_inst_valid = 1'b0;
            end
            begin
                int g;
                g = 0;
                while (instruction == 0 && g < 10) begin
                    tick();
                    g++;
                end
                chk("b2b_started", (instruction != 0), 1);
                for (int i = 0; i < 26; i++) begin
                    chk($sformatf("b2b_inst%0d", i), instruction, words[i]);
                    chk($sformatf("b2b_start%0d", i), inst_start, 1);
                    tick();
                end
            end
        join
        chk("b2b_after", instruction, 0);
        chk("b2b_issued", issued_count, 26);

        // Full queue under stall; 17th word retried after the first pop
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 17; i++) words[i] = mk(4'd1, 8'(i), 8'd9, 128'(i + 100));
        for (int i = 0; i < 16; i++) begin
            s_inst_valid = 1'b1; s_inst_data = words[i];
            tick();
        end
        s_inst_data = words[16];
        tick();
        chk("full_ready", s_inst_ready, 0);
        chk("full_count", fifo_count, 16);
        chk("full_inst", instruction, 0);
        stall = 1'b0;
        tick();
        chk("full_pop0", instruction, words[0]);
        chk("full_ready_after", s_inst_ready, 1);
        chk("full_count_after", fifo_count, 15);
        tick();
        s_inst_valid = 1'b0;
        chk("full_pushpop_count", fifo_count, 15);
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("full_inst%0d", i), instruction, words[i]);
            tick();
        end
        chk("full_drained", instruction, 0);
        chk("full_empty_count", fifo_count, 0);

        // Stall for 10 cycles starting at cycle 20 of a MAT_MUL
        do_reset();
        w  = mk(4'd5, 8'd1, 8'd2, 128'hdead_beef);
        w2 = mk(4'd2, 8'd4, 8'd5, 128'hcafe);
        s_inst_valid = 1'b1; s_inst_data = w;
        tick();
        s_inst_data = w2;
        tick();
        s_inst_valid = 1'b0;
        held = 0; guard = 0;
        while (instruction == w && guard < 200) begin
            held++;
            stall = (held >= 20 && held < 30);
            tick();
            guard++;
        end
        stall = 1'b0;
        chk("stall_hold_len", held, 58);
        chk("stall_next", instruction, w2);
        chk("stall_next_start", inst_start, 1);

        // Reset in the middle of a MAT_MUL with 5 queued
        do_reset();
        s_inst_valid = 1'b1; s_inst_data = w;
        tick();
        for (int i = 0; i < 5; i++) begin
            s_inst_data = mk(4'd1, 8'(i), 8'd0, 128'(i + 1));
            tick();
        end
        s_inst_valid = 1'b0;
        tick(); tick();
        chk("midrst_pre_count", fifo_count, 5);
        chk("midrst_pre_inst", instruction, w);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_inst", instruction, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_issued", issued_count, 0);
        chk("midrst_busy", busy, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_quiet_inst", instruction, 0);
        chk("midrst_quiet_issued", issued_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
